// File: rtl/challenge_collector.sv
// challenge_collector: gathers WIDTH serial generator bits into a parallel challenge word
// and offers it on a valid/ready handshake, with stuck-word detection and abort.
module challenge_collector #(
    parameter int WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             msb_first_i,
    input  logic             continuous_i,
    input  logic             gen_bit_i,
    input  logic             gen_valid_i,
    output logic             gen_en_o,
    output logic [WIDTH-1:0] challenge_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             stuck_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] bit_cnt_o
);
    typedef enum logic [1:0] {IDLE, SAMPLE, HOLD} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   chal_q, chal_d, shf;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stuck_q, stuck_d;
    logic               msb_q, msb_d;
    logic               cont_q, cont_d;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            chal_q  <= '0;
            cnt_q   <= '0;
            stuck_q <= 1'b0;
            msb_q   <= 1'b0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chal_q  <= chal_d;
            cnt_q   <= cnt_d;
            stuck_q <= stuck_d;
            msb_q   <= msb_d;
            cont_q  <= cont_d;
        end
    end

    assign shf = msb_q ? {chal_q[WIDTH-2:0], gen_bit_i} : {gen_bit_i, chal_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        chal_d  = chal_q;
        cnt_d   = cnt_q;
        stuck_d = stuck_q;
        msb_d   = msb_q;
        cont_d  = cont_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = SAMPLE;
                chal_d  = '0;
                cnt_d   = '0;
                msb_d   = msb_first_i;
                cont_d  = continuous_i;
            end
            SAMPLE: if (abort_i) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (gen_valid_i) begin
                chal_d = shf;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    stuck_d = (&shf) | ~(|shf);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: if (out_ready_i) begin
                stuck_d = 1'b0;
                state_d = cont_q ? SAMPLE : IDLE;
                chal_d  = cont_q ? '0 : chal_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gen_en_o    = state_q == SAMPLE;
    assign out_valid_o = state_q == HOLD;
    assign busy_o      = state_q != IDLE;
    assign stuck_o     = stuck_q;
    assign challenge_o = chal_q;
    assign bit_cnt_o   = cnt_q;
endmodule

// File: tb/tb_challenge_collector.sv
// tb_challenge_collector: directed vectors against WIDTH=8 and WIDTH=64 collectors.
module tb_challenge_collector;
    logic        clk = 1'b0;
    logic        reset = 1'b0, start8 = 1'b0, start64 = 1'b0, abort = 1'b0;
    logic        msb_first = 1'b1, continuous = 1'b0, gen_bit = 1'b0, gen_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        gen_en8, ov8, stuck8, busy8, gen_en64, ov64, stuck64, busy64;
    logic [7:0]  ch8;
    logic [2:0]  cnt8;
    logic [63:0] ch64;
    logic [5:0]  cnt64;
    int          n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    challenge_collector #(.WIDTH(8)) u8 (
        .clk_i(clk), .reset_i(reset), .start_i(start8), .abort_i(abort),
        .msb_first_i(msb_first), .continuous_i(continuous), .gen_bit_i(gen_bit),
        .gen_valid_i(gen_valid), .gen_en_o(gen_en8), .challenge_o(ch8),
        .out_valid_o(ov8), .out_ready_i(out_ready), .stuck_o(stuck8),
        .busy_o(busy8), .bit_cnt_o(cnt8)
    );

    challenge_collector #(.WIDTH(64)) u64 (
        .clk_i(clk), .reset_i(reset), .start_i(start64), .abort_i(abort),
        .msb_first_i(msb_first), .continuous_i(continuous), .gen_bit_i(gen_bit),
        .gen_valid_i(gen_valid), .gen_en_o(gen_en64), .challenge_o(ch64),
        .out_valid_o(ov64), .out_ready_i(out_ready), .stuck_o(stuck64),
        .busy_o(busy64), .bit_cnt_o(cnt64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin8(input logic msb, input logic cont);
        msb_first = msb; continuous = cont; start8 = 1'b1;
        step();
        start8 = 1'b0; msb_first = ~msb; continuous = ~cont;
    endtask

    // feeds pat MSB first in time; gap inserts an idle gen_valid=0 cycle before each bit
    task automatic feed8(input logic [7:0] pat, input logic gap, output int en_cycles);
        en_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            if (gap) begin
                gen_valid = 1'b0;
                en_cycles += int'(gen_en8);
                step();
                chk("gap_cnt_hold", 64'(cnt8), 64'(i));
            end
            gen_valid = 1'b1; gen_bit = pat[7-i];
            en_cycles += int'(gen_en8);
            step();
            if (i == 6) chk("ov_before_last", 64'(ov8), 64'd0);
        end
        gen_valid = 1'b0;
    endtask

    initial begin
        int en, hs, ovs;
        logic [63:0] p64;
        step();
        chk("rst_ch", 64'(ch8), 64'd0);
        chk("rst_ov", 64'(ov8), 64'd0);
        chk("rst_en", 64'(gen_en8), 64'd0);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_stuck", 64'(stuck8), 64'd0);
        chk("rst_cnt", 64'(cnt8), 64'd0);
        reset = 1'b1;
        // msb-first: out_valid on the 9th edge from start
        begin8(1'b1, 1'b0);
        chk("t1_en", 64'(gen_en8), 64'd1);
        feed8(8'hB3, 1'b0, en);
        chk("t1_ov", 64'(ov8), 64'd1);
        chk("t1_ch", 64'(ch8), 64'hB3);
        chk("t1_stuck", 64'(stuck8), 64'd0);
        chk("t1_cnt", 64'(cnt8), 64'd0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t1_ov_drop", 64'(ov8), 64'd0);
        chk("t1_idle", 64'(busy8), 64'd0);
        chk("t1_keep", 64'(ch8), 64'hB3);
        // lsb-first
        begin8(1'b0, 1'b0);
        feed8(8'hB3, 1'b0, en);
        chk("t2_ch", 64'(ch8), 64'hCD);
        chk("t2_en_cycles", 64'(en), 64'd8);
        chk("t2_en_hold", 64'(gen_en8), 64'd0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        // gen_valid toggling
        begin8(1'b1, 1'b0);
        feed8(8'hB3, 1'b1, en);
        chk("t3_ch", 64'(ch8), 64'hB3);
        chk("t3_sample_cycles", 64'(en), 64'd16);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        // all-zero word, held
        begin8(1'b1, 1'b0);
        feed8(8'h00, 1'b0, en);
        chk("t4_stuck", 64'(stuck8), 64'd1);
        for (int i = 0; i < 10; i++) begin
            abort = 1'b1; start8 = 1'b1;
            step();
            chk("t4_hold_ov", 64'(ov8), 64'd1);
            chk("t4_hold_ch", 64'(ch8), 64'h00);
            chk("t4_hold_stuck", 64'(stuck8), 64'd1);
        end
        abort = 1'b0; start8 = 1'b0;
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t4_ov_drop", 64'(ov8), 64'd0);
        chk("t4_busy", 64'(busy8), 64'd0);
        chk("t4_stuck_clr", 64'(stuck8), 64'd0);
        // continuous back-to-back
        out_ready = 1'b1; hs = 0;
        begin8(1'b1, 1'b1);
        feed8(8'hB3, 1'b0, en);
        chk("t5_w0", 64'(ch8), 64'hB3);
        hs += int'(ov8);
        chk("t5_gap_en", 64'(gen_en8), 64'd0);
        step();
        chk("t5_restart_en", 64'(gen_en8), 64'd1);
        chk("t5_restart_ch", 64'(ch8), 64'h00);
        feed8(8'h5A, 1'b0, en);
        chk("t5_w1", 64'(ch8), 64'h5A);
        hs += int'(ov8);
        step();
        chk("t5_restart_en2", 64'(gen_en8), 64'd1);
        feed8(8'hFF, 1'b0, en);
        chk("t5_w2", 64'(ch8), 64'hFF);
        chk("t5_stuck1", 64'(stuck8), 64'd1);
        hs += int'(ov8);
        chk("t5_handshakes", 64'(hs), 64'd3);
        out_ready = 1'b0;
        reset = 1'b0; step(); reset = 1'b1;
        // WIDTH=64 run
        p64 = 64'h0123456789ABCDEF; ovs = 0;
        msb_first = 1'b1; continuous = 1'b0; start64 = 1'b1;
        step();
        start64 = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            gen_valid = 1'b1; gen_bit = p64[63-i];
            step();
            ovs += int'(ov64);
        end
        gen_valid = 1'b0;
        chk("t5_w64_ch", ch64, p64);
        for (int i = 0; i < 3; i++) begin
            step();
            ovs += int'(ov64);
        end
        chk("t5_w64_once", 64'(ovs), 64'd1);
        out_ready = 1'b0;
        // abort at bit 5
        begin8(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            gen_valid = 1'b1; gen_bit = 1'b1; step();
        end
        chk("t6_cnt5", 64'(cnt8), 64'd5);
        abort = 1'b1; step(); abort = 1'b0; gen_valid = 1'b0;
        chk("t6_abort_busy", 64'(busy8), 64'd0);
        chk("t6_abort_ov", 64'(ov8), 64'd0);
        chk("t6_abort_cnt", 64'(cnt8), 64'd0);
        // abort beats a simultaneous last bit
        begin8(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            gen_valid = 1'b1; step();
        end
        abort = 1'b1; step(); abort = 1'b0; gen_valid = 1'b0;
        chk("t6_abort_last_ov", 64'(ov8), 64'd0);
        chk("t6_abort_last_busy", 64'(busy8), 64'd0);
        // reset mid-capture, with start asserted
        begin8(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            gen_valid = 1'b1; gen_bit = 1'b1; step();
        end
        reset = 1'b0; start8 = 1'b1; step();
        chk("t6_rst_ch", 64'(ch8), 64'd0);
        chk("t6_rst_cnt", 64'(cnt8), 64'd0);
        chk("t6_rst_en", 64'(gen_en8), 64'd0);
        chk("t6_rst_busy", 64'(busy8), 64'd0);
        chk("t6_rst_ov", 64'(ov8), 64'd0);
        reset = 1'b1; start8 = 1'b0; gen_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
